fft_input_framer: RTL and testbench

Receive-side endpoint of the FFT sample-load stream: accepts the `i_valid`/`i_re`/`i_im` burst that a board wrapper or upstream source drives, and assembles eight complex float32 samples into a frame buffer. Each sample is stored at its bit-reversed address, so the radix-2 DIT butterfly stages of the 8-point core can read operands in the order they need. The framer sits between the load source and the FFT core's first butterfly stage. It signals frame completion and holds the frame until the consumer acknowledges it.

---
 rtl/fft_input_framer.sv | 112 +++++++++++
 tb/tb_fft_input_framer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_framer.sv
// fft_input_framer
// Receive-side endpoint of the FFT sample-load stream. Collects eight complex
// samples into a frame buffer and holds the frame until the consumer acks it.
// Build option: define FFT_FRAMER_BITREV_EN to store samples at bit-reversed
// addresses (DIT input order); leave it undefined for natural order.
module fft_input_framer #(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_re,
   input  logic [DATA_W-1:0] i_im,
   output logic              o_ready,
   output logic              o_frame_valid,
   input  logic              i_frame_ack,
   input  logic [2:0]        i_rd_addr,
   output logic [DATA_W-1:0] o_rd_re,
   output logic [DATA_W-1:0] o_rd_im,
   output logic [3:0]        o_count,
   output logic              o_overflow
);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t              state;
   logic [2*DATA_W-1:0] frame_mem [8];
   logic                accept;
   logic [2:0]          wr_addr;

   // Storage slot for the k-th sample of a frame.
   function automatic logic [2:0] wa(input logic [2:0] k);
`ifdef FFT_FRAMER_BITREV_EN
      return {k[0], k[1], k[2]};
`else
      return k;
`endif
   endfunction

   // Handshake outputs come straight from the state register, never from inputs.
   assign o_ready       = (state == FILL);
   assign o_frame_valid = (state == FULL);

   // A restart in the same cycle discards the offered sample.
   assign accept  = i_valid & o_ready & ~i_start;
   assign wr_addr = wa(o_count[2:0]);

   // Frame control: state, sample count and sticky overflow.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= FILL;
         o_count    <= 4'd0;
         o_overflow <= 1'b0;
      end else if (i_start) begin
         state      <= FILL;
         o_count    <= 4'd0;
         o_overflow <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  o_count <= o_count + 4'd1;
                  if (o_count == 4'd7) begin
                     state <= FULL;
                  end
               end
            end
            FULL: begin
               // o_ready is low here, so any offered sample is an overflow,
               // including one that coincides with the ack.
               if (i_valid) begin
                  o_overflow <= 1'b1;
               end
               if (i_frame_ack) begin
                  state   <= FILL;
                  o_count <= 4'd0;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

   // Frame buffer write port.
   // NOTE: the buffer has no reset on purpose; it maps onto plain RAM/regfile
   // cells and consumers only read entries a completed frame has written.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         frame_mem[wr_addr] <= {i_re, i_im};
      end
   end

   // Registered read port; same-address write in this cycle returns old data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rd_re <= '0;
         o_rd_im <= '0;
      end else begin
         o_rd_re <= frame_mem[i_rd_addr][2*DATA_W-1:DATA_W];
         o_rd_im <= frame_mem[i_rd_addr][DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer
// Directed bench for fft_input_framer with a reference buffer and a queue of
// expected read-port values. Follows FFT_FRAMER_BITREV_EN like the design.
module tb_fft_input_framer;

   localparam int DATA_W = 32;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_start;
   logic              i_valid;
   logic [DATA_W-1:0] i_re;
   logic [DATA_W-1:0] i_im;
   logic              o_ready;
   logic              o_frame_valid;
   logic              i_frame_ack;
   logic [2:0]        i_rd_addr;
   logic [DATA_W-1:0] o_rd_re;
   logic [DATA_W-1:0] o_rd_im;
   logic [3:0]        o_count;
   logic              o_overflow;

   int checks = 0;
   int errors = 0;

   logic [63:0] model_mem [8];
   logic        model_wr  [8];
   logic [63:0] sb_q [$];

   fft_input_framer #(.DATA_W(DATA_W)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_valid       (i_valid),
      .i_re          (i_re),
      .i_im          (i_im),
      .o_ready       (o_ready),
      .o_frame_valid (o_frame_valid),
      .i_frame_ack   (i_frame_ack),
      .i_rd_addr     (i_rd_addr),
      .o_rd_re       (o_rd_re),
      .o_rd_im       (o_rd_im),
      .o_count       (o_count),
      .o_overflow    (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
      $fatal(1, "watchdog expired");
   end

   // Expected storage slot of sample k, built bit by bit.
   function automatic logic [2:0] slot(input int k);
      logic [2:0] kk;
      logic [2:0] r;
      kk = 3'(k);
      r  = kk;
`ifdef FFT_FRAMER_BITREV_EN
      for (int b = 0; b < 3; b++) begin
         r[b] = kk[2-b];
      end
`endif
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One clock cycle with the given controls, then return them to idle.
   task automatic drive(input logic valid, input logic start, input logic ack,
                        input logic [31:0] re, input logic [31:0] im);
      i_valid     = valid;
      i_start     = start;
      i_frame_ack = ack;
      i_re        = re;
      i_im        = im;
      tick();
      i_valid     = 1'b0;
      i_start     = 1'b0;
      i_frame_ack = 1'b0;
   endtask

   // Accepted sample k; also watches the target slot to confirm the read in
   // the write cycle still sees the previous contents.
   task automatic load_sample(input int k, input logic [31:0] re, input logic [31:0] im,
                              input logic ack);
      logic [2:0] a;
      logic       have_old;
      a         = slot(k);
      i_rd_addr = a;
      have_old  = model_wr[a];
      if (have_old) sb_q.push_back(model_mem[a]);
      drive(1'b1, 1'b0, ack, re, im);
      if (have_old) check("rd_before_wr", {o_rd_re, o_rd_im}, sb_q.pop_front());
      model_mem[a] = {re, im};
      model_wr[a]  = 1'b1;
   endtask

   task automatic read_check(input logic [2:0] a, input string tag);
      i_rd_addr = a;
      sb_q.push_back(model_mem[a]);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      check(tag, {o_rd_re, o_rd_im}, sb_q.pop_front());
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model_wr[i] = 1'b0;
      i_rst_n     = 1'b0;
      i_start     = 1'b0;
      i_valid     = 1'b0;
      i_frame_ack = 1'b0;
      i_re        = '0;
      i_im        = '0;
      i_rd_addr   = 3'd0;

      // Reset values
      #2;
      check("rst_ready",  64'(o_ready),       64'd1);
      check("rst_fvalid", 64'(o_frame_valid), 64'd0);
      check("rst_count",  64'(o_count),       64'd0);
      check("rst_ovf",    64'(o_overflow),    64'd0);
      check("rst_rd",     {o_rd_re, o_rd_im}, 64'd0);
      #10;
      i_rst_n = 1'b1;

      // Frame A: back-to-back fill, bit-reversed or natural placement
      for (int k = 0; k < 8; k++) begin
         load_sample(k, 32'h4036A800 + 32'(k), 32'hC01E1800 + 32'(k), 1'b0);
         check("fill_count", 64'(o_count), 64'(k + 1));
         check("fill_fvalid", 64'(o_frame_valid), (k == 7) ? 64'd1 : 64'd0);
      end
      check("full_ready", 64'(o_ready), 64'd0);
`ifdef FFT_FRAMER_BITREV_EN
      i_rd_addr = 3'd4;
      tick();
      check("addr4_re", 64'(o_rd_re), 64'h4036A801);
      i_rd_addr = 3'd6;
      tick();
      check("addr6_re", 64'(o_rd_re), 64'h4036A803);
`else
      i_rd_addr = 3'd4;
      tick();
      check("addr4_re", 64'(o_rd_re), 64'h4036A804);
`endif
      for (int a = 0; a < 8; a++) read_check(3'(a), "frame_a_rd");

      // Overflow while FULL, then ack with a sample offered in the same cycle
      drive(1'b1, 1'b0, 1'b0, 32'hDEAD0000, 32'hDEAD0001);
      check("ovf1_flag",  64'(o_overflow), 64'd1);
      check("ovf1_count", 64'(o_count),    64'd8);
      drive(1'b1, 1'b0, 1'b0, 32'hDEAD0002, 32'hDEAD0003);
      check("ovf2_fvalid", 64'(o_frame_valid), 64'd1);
      read_check(slot(0), "ovf_buf0");
      read_check(slot(7), "ovf_buf7");
      drive(1'b1, 1'b0, 1'b1, 32'hDEAD0004, 32'hDEAD0005);
      check("ack_ready",  64'(o_ready),       64'd1);
      check("ack_fvalid", 64'(o_frame_valid), 64'd0);
      check("ack_count",  64'(o_count),       64'd0);
      check("ack_ovf",    64'(o_overflow),    64'd1);
      read_check(slot(1), "ack_buf1");

      // Restart mid-frame: 5 samples, then start with a concurrent sample
      for (int k = 0; k < 5; k++) begin
         load_sample(k, 32'h11110000 + 32'(k), 32'h22220000 + 32'(k), 1'b0);
      end
      check("pre_start_count", 64'(o_count), 64'd5);
      drive(1'b1, 1'b1, 1'b0, 32'hBAD0BAD0, 32'hBAD1BAD1);
      check("start_count", 64'(o_count),    64'd0);
      check("start_ovf",   64'(o_overflow), 64'd0);
      check("start_ready", 64'(o_ready),    64'd1);
      read_check(slot(5), "start_not_written");
      for (int k = 0; k < 8; k++) begin
         load_sample(k, 32'h33330000 + 32'(k), 32'h44440000 + 32'(k), 1'b0);
      end
      check("restart_fvalid", 64'(o_frame_valid), 64'd1);
      for (int a = 0; a < 8; a++) read_check(3'(a), "frame_c_rd");
      drive(1'b0, 1'b0, 1'b1, '0, '0);
      check("ack2_count", 64'(o_count), 64'd0);

      // Gapped input: valid on even cycles, a stray ack on the idle ones
      for (int i = 0; i < 15; i++) begin
         if (i % 2 == 0) begin
            load_sample(i / 2, 32'h55550000 + 32'(i), 32'h66660000 + 32'(i), 1'b0);
         end else begin
            drive(1'b0, 1'b0, 1'b1, '0, '0);
         end
         check("gap_count", 64'(o_count), 64'(i / 2 + 1));
         check("gap_fvalid", 64'(o_frame_valid), (i == 14) ? 64'd1 : 64'd0);
      end
      for (int a = 0; a < 8; a++) read_check(3'(a), "frame_d_rd");
      drive(1'b0, 1'b0, 1'b1, '0, '0);

      // Asynchronous reset after 3 samples, checked between clock edges
      for (int k = 0; k < 3; k++) begin
         load_sample(k, 32'h77770000 + 32'(k), 32'h88880000 + 32'(k), 1'b0);
      end
      read_check(slot(0), "pre_rst_rd");
      check("pre_rst_count", 64'(o_count), 64'd3);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("arst_count",  64'(o_count),       64'd0);
      check("arst_ready",  64'(o_ready),       64'd1);
      check("arst_fvalid", 64'(o_frame_valid), 64'd0);
      check("arst_ovf",    64'(o_overflow),    64'd0);
      check("arst_rd",     {o_rd_re, o_rd_im}, 64'd0);
      #2;
      i_rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      check("post_rst_count", 64'(o_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
